fwht_reorder: RTL and testbench
===============================

FWHT_REORDER -- requirements
Module: fwht_reorder

Interface
REQ-001 Parameter WIDTH, default 32, coefficient width in bits.
REQ-002 Parameter L_WIDTH, default 12, log2 of frame length N = 2^L_WIDTH.
REQ-003 ACLK  input  1  sole clock; all state updates on rising edge.
REQ-004 ARESETN  input  1  asynchronous, active-low reset.
REQ-005 s_axis_tdata  input  WIDTH  transform coefficient from the fwht output.
REQ-006 s_axis_tvalid  input  1  coefficient valid; upstream does not stall.
REQ-007 s_index  input  L_WIDTH  sequency position of the current coefficient.
REQ-008 s_axis_tready  output  1  high when the current write bank is free; informational only.
REQ-009 m_axis_tdata  output  WIDTH  coefficient in ascending sequency order.
REQ-010 m_axis_tvalid  output  1  output word valid.
REQ-011 m_axis_tready  input  1  downstream accept.
REQ-012 overflow  output  1  sticky flag: a coefficient arrived while no bank was free.

Function
REQ-013 Block SHALL hold two banks (ping-pong), each of N words by WIDTH bits, with per-bank full flags.
REQ-014 On s_axis_tvalid with the write bank not full, block SHALL write s_axis_tdata at address s_index and increment the write count.
REQ-015 When the N-th word of a frame is written, block SHALL set that bank's full flag, toggle the write bank, and clear the write count, all in the same cycle.
REQ-016 On s_axis_tvalid with the write bank full, block SHALL drop the word, leave the count unchanged, and set overflow.
REQ-017 s_axis_tready SHALL equal NOT full[wr_bank], derived from registered flags.
REQ-018 The read FSM SHALL have three states: IDLE, PRIME, STREAM.
REQ-019 IDLE->PRIME when full[rd_bank] is set; PRIME issues a RAM read of address 0 (1-cycle read latency).
REQ-020 PRIME->STREAM on the next cycle; m_axis_tvalid SHALL rise 2 cycles after full[rd_bank] is set.
REQ-021 In STREAM, a word SHALL transfer only when m_axis_tvalid and m_axis_tready are both high; m_axis_tdata and m_axis_tvalid SHALL hold stable while m_axis_tready is low.
REQ-022 Output words SHALL be addresses 0..N-1 in ascending order; throughput SHALL be 1 word/cycle under continuous m_axis_tready.
REQ-023 On transfer of address N-1, block SHALL clear full[rd_bank], toggle rd_bank, and return to IDLE. If the other bank is already full, it SHALL go to PRIME on the next cycle.
REQ-024 A bank release and a bank fill in the same cycle SHALL both take effect.
REQ-025 Duplicate s_index values within a frame SHALL overwrite; no check is made.

Reset
REQ-026 While ARESETN is low: m_axis_tvalid=0, m_axis_tdata=0, overflow=0, s_axis_tready=1, both full flags=0, wr_bank=rd_bank=0, write count=0, FSM=IDLE.
REQ-027 RAM contents SHALL NOT be reset. A reset mid-frame SHALL discard partial and full frames without emitting any output.

Configuration
REQ-028 Macro FWHT_REORDER_TLAST_EN defined: add output m_axis_tlast (1 bit), high with the word at address N-1 and reset to 0.
REQ-029 Macro FWHT_REORDER_TLAST_EN undefined: m_axis_tlast port and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 A shared package SHALL hold the read FSM state enum (IDLE, PRIME, STREAM) and the default WIDTH/L_WIDTH constants.
REQ-031 One sub-module, fwht_reorder_bank, SHALL be used twice: a simple dual-port RAM (N x WIDTH, 1 write port, 1 registered read port).

Verification
REQ-032 With L_WIDTH=3 and continuous tready, feed data 10..17 with s_index 7,6,...,0 -> outputs 17,16,...,10; first m_axis_tvalid 2 cycles after the 8th input.
REQ-033 Feed two back-to-back frames, with m_axis_tready toggling 1,0,1,0 -> all 16 words in order, none lost or duplicated, data stable while stalled, overflow=0.
REQ-034 Hold m_axis_tready=0 and feed 3 frames -> s_axis_tready=0 after frame 2, frame 3 dropped, overflow=1 until reset; frames 1 and 2 then drain correctly.
REQ-035 Assert ARESETN low after 5 words of a frame, then release and feed a full frame -> only the new frame appears; all outputs hold reset values during reset.
REQ-036 With FWHT_REORDER_TLAST_EN defined, run the frame from REQ-032 -> m_axis_tlast=1 only on the word carrying value 10 (address 7). Build with the macro undefined -> compiles with no m_axis_tlast port.

Source files
------------

// File: rtl/fwht_reorder_pkg.sv
// Shared definitions for the FWHT sequency reorder buffer: read FSM states and default sizes.
package fwht_reorder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } rd_state_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_L_WIDTH = 12;

endpackage

// File: rtl/fwht_reorder_bank.sv
// One ping-pong bank: simple dual-port RAM, one write port, one registered read port.
module fwht_reorder_bank
    import fwht_reorder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_L_WIDTH
) (
    input  logic              ACLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];
    logic [WIDTH-1:0] rd_data_reg;

    // No reset on purpose so the array maps onto block RAM.
    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/fwht_reorder.sv
// Ping-pong reorder buffer: writes FWHT coefficients by sequency index, streams them out in order.
// Optional m_axis_tlast output enabled by defining FWHT_REORDER_TLAST_EN.
module fwht_reorder
    import fwht_reorder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int L_WIDTH = DEF_L_WIDTH
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic [WIDTH-1:0]   s_axis_tdata,
    input  logic               s_axis_tvalid,
    input  logic [L_WIDTH-1:0] s_index,
    output logic               s_axis_tready,
    output logic [WIDTH-1:0]   m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
`ifdef FWHT_REORDER_TLAST_EN
    output logic               m_axis_tlast,
`endif
    output logic               overflow
);

    localparam logic [L_WIDTH-1:0] LAST_ADDR = '1;

    logic               wr_bank_reg,  wr_bank_next;
    logic               rd_bank_reg,  rd_bank_next;
    logic [1:0]         full_reg,     full_next;
    logic [L_WIDTH-1:0] wr_count_reg, wr_count_next;
    logic               overflow_reg, overflow_next;
    rd_state_t          state_reg,    state_next;
    logic [L_WIDTH-1:0] out_addr_reg, out_addr_next;

    logic [1:0]         bank_we;
    logic [1:0]         bank_re;
    logic [L_WIDTH-1:0] rd_addr;
    logic [WIDTH-1:0]   rd_data [2];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_bank_reg  <= 1'b0;
            rd_bank_reg  <= 1'b0;
            full_reg     <= 2'b00;
            wr_count_reg <= '0;
            overflow_reg <= 1'b0;
            state_reg    <= ST_IDLE;
            out_addr_reg <= '0;
        end else begin
            wr_bank_reg  <= wr_bank_next;
            rd_bank_reg  <= rd_bank_next;
            full_reg     <= full_next;
            wr_count_reg <= wr_count_next;
            overflow_reg <= overflow_next;
            state_reg    <= state_next;
            out_addr_reg <= out_addr_next;
        end
    end

    always_comb begin
        wr_bank_next  = wr_bank_reg;
        rd_bank_next  = rd_bank_reg;
        full_next     = full_reg;
        wr_count_next = wr_count_reg;
        overflow_next = overflow_reg;
        state_next    = state_reg;
        out_addr_next = out_addr_reg;
        bank_we       = 2'b00;
        bank_re       = 2'b00;
        rd_addr       = '0;

        // Write side: the bank being read is always full, so fill and release never hit the same bank.
        if (s_axis_tvalid) begin
            if (full_reg[wr_bank_reg]) begin
                overflow_next = 1'b1;
            end else begin
                bank_we[wr_bank_reg] = 1'b1;
                if (wr_count_reg == LAST_ADDR) begin
                    full_next[wr_bank_reg] = 1'b1;
                    wr_bank_next           = ~wr_bank_reg;
                    wr_count_next          = '0;
                end else begin
                    wr_count_next = wr_count_reg + 1'b1;
                end
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (full_reg[rd_bank_reg]) begin
                    state_next = ST_PRIME;
                end
            end
            ST_PRIME: begin
                bank_re[rd_bank_reg] = 1'b1;
                out_addr_next        = '0;
                state_next           = ST_STREAM;
            end
            ST_STREAM: begin
                // The read register only advances on a transfer, so data holds during a stall.
                if (m_axis_tready) begin
                    if (out_addr_reg == LAST_ADDR) begin
                        full_next[rd_bank_reg] = 1'b0;
                        rd_bank_next           = ~rd_bank_reg;
                        state_next             = ST_IDLE;
                    end else begin
                        bank_re[rd_bank_reg] = 1'b1;
                        rd_addr              = out_addr_reg + 1'b1;
                        out_addr_next        = out_addr_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            fwht_reorder_bank #(
                .WIDTH  (WIDTH),
                .ADDR_W (L_WIDTH)
            ) u_bank (
                .ACLK    (ACLK),
                .wr_en   (bank_we[gi]),
                .wr_addr (s_index),
                .wr_data (s_axis_tdata),
                .rd_en   (bank_re[gi]),
                .rd_addr (rd_addr),
                .rd_data (rd_data[gi])
            );
        end
    endgenerate

    assign s_axis_tready = ~full_reg[wr_bank_reg];
    assign m_axis_tvalid = (state_reg == ST_STREAM);
    // Gate data so it reads zero whenever nothing is being presented, including reset.
    assign m_axis_tdata  = m_axis_tvalid ? rd_data[rd_bank_reg] : '0;
    assign overflow      = overflow_reg;

`ifdef FWHT_REORDER_TLAST_EN
    assign m_axis_tlast = m_axis_tvalid && (out_addr_reg == LAST_ADDR);
`endif

endmodule

// File: tb/tb_fwht_reorder.sv
// Directed bench for fwht_reorder with an 8-word frame (L_WIDTH=3).
module tb_fwht_reorder;

    localparam int W  = 16;
    localparam int LW = 3;
    localparam int N  = 8;

    logic          ACLK;
    logic          ARESETN;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic [LW-1:0] s_index;
    logic          s_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          overflow;
    logic          tlast_obs;
`ifdef FWHT_REORDER_TLAST_EN
    logic          m_axis_tlast;
    assign tlast_obs = m_axis_tlast;
`else
    assign tlast_obs = 1'b0;
`endif

    fwht_reorder #(.WIDTH(W), .L_WIDTH(LW)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_index       (s_index),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
`ifdef FWHT_REORDER_TLAST_EN
        .m_axis_tlast  (m_axis_tlast),
`endif
        .overflow      (overflow)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } out_t;

    typedef struct {
        logic [LW-1:0] idx;
        logic [W-1:0]  data;
        logic [W-1:0]  exp_out;
    } vec_t;

    out_t got_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   hold_errs = 0;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    vec_t vecs [N];

    // Output monitor: records transfers and watches that stalled words hold still.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(m_axis_tvalid && m_axis_tdata == prev_data)) begin
                hold_errs = hold_errs + 1;
                $display("hold violated: valid=%0b data=%0d held=%0d", m_axis_tvalid, m_axis_tdata, prev_data);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back('{data: m_axis_tdata, last: tlast_obs});
                $display("xfer data=%0d last=%0b", m_axis_tdata, tlast_obs);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send(input logic [LW-1:0] idx, input logic [W-1:0] data);
        s_axis_tvalid = 1'b1;
        s_index       = idx;
        s_axis_tdata  = data;
        cyc();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        chk({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
        chk({tag, "_tready"}, 32'(s_axis_tready), 32'd1);
        chk({tag, "_ovf"},    32'(overflow),      32'd0);
    endtask

    task automatic do_reset();
        #1;
        ARESETN = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (3) cyc();
        check_reset_outputs("rst_hold");
        ARESETN = 1'b1;
        cyc();
    endtask

    task automatic wait_words(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            cyc();
            k++;
        end
        chk(name, 32'(got_q.size()), 32'(n));
    endtask

    task automatic check_seq(input string name, input int pos, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (pos + i < got_q.size())
                chk(name, 32'(got_q[pos+i].data), 32'(base + i));
        end
    endtask

    initial begin
        ARESETN       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_index       = '0;
        m_axis_tready = 1'b1;
        repeat (2) cyc();

        // Frame with reversed indices: data 10..17 at s_index 7..0.
        vecs[0] = '{3'd7, 16'd10, 16'd17};
        vecs[1] = '{3'd6, 16'd11, 16'd16};
        vecs[2] = '{3'd5, 16'd12, 16'd15};
        vecs[3] = '{3'd4, 16'd13, 16'd14};
        vecs[4] = '{3'd3, 16'd14, 16'd13};
        vecs[5] = '{3'd2, 16'd15, 16'd12};
        vecs[6] = '{3'd1, 16'd16, 16'd11};
        vecs[7] = '{3'd0, 16'd17, 16'd10};

        // Reversed frame, latency and order.
        do_reset();
        got_q.delete();
        for (int i = 0; i < N; i++) send(vecs[i].idx, vecs[i].data);
        chk("t1_valid_at_fill", 32'(m_axis_tvalid), 32'd0);
        chk("t1_tready_after_fill", 32'(s_axis_tready), 32'd1);
        cyc();
        chk("t1_valid_prime", 32'(m_axis_tvalid), 32'd0);
        cyc();
        chk("t1_valid_rise", 32'(m_axis_tvalid), 32'd1);
        chk("t1_first_data", 32'(m_axis_tdata), 32'd17);
        wait_words("t1_count", N, 40);
        for (int i = 0; i < N; i++) begin
            if (i < got_q.size()) begin
                chk("t1_data", 32'(got_q[i].data), 32'(vecs[i].exp_out));
`ifdef FWHT_REORDER_TLAST_EN
                chk("t1_tlast", 32'(got_q[i].last), (i == N-1) ? 32'd1 : 32'd0);
`endif
            end
        end

        // Two back-to-back frames, downstream toggling ready.
        got_q.delete();
        fork
            begin
                for (int i = 0; i < N; i++) send(LW'(i), W'(100 + i));
                send(3'd3, 16'd203); send(3'd1, 16'd201); send(3'd0, 16'd200); send(3'd2, 16'd202);
                send(3'd7, 16'd207); send(3'd5, 16'd205); send(3'd6, 16'd206); send(3'd4, 16'd204);
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    m_axis_tready = (i % 2 == 0);
                    cyc();
                end
            end
        join
        m_axis_tready = 1'b1;
        wait_words("t2_count", 2*N, 60);
        check_seq("t2_frame_a", 0, 100, N);
        check_seq("t2_frame_b", N, 200, N);
        repeat (6) cyc();
        chk("t2_no_extra", 32'(got_q.size()), 32'(2*N));
        chk("t2_overflow", 32'(overflow), 32'd0);
        chk("t2_hold_errs", 32'(hold_errs), 32'd0);

        // Three frames with downstream stalled: third is dropped.
        do_reset();
        got_q.delete();
        m_axis_tready = 1'b0;
        for (int i = 0; i < N; i++) send(LW'(i), W'(300 + i));
        chk("t3_tready_f1", 32'(s_axis_tready), 32'd1);
        for (int i = 0; i < N; i++) send(LW'(i), W'(400 + i));
        chk("t3_tready_f2", 32'(s_axis_tready), 32'd0);
        chk("t3_ovf_before", 32'(overflow), 32'd0);
        for (int i = 0; i < N; i++) send(LW'(i), W'(500 + i));
        chk("t3_ovf_after", 32'(overflow), 32'd1);
        chk("t3_stall_valid", 32'(m_axis_tvalid), 32'd1);
        chk("t3_stall_data", 32'(m_axis_tdata), 32'd300);
        m_axis_tready = 1'b1;
        wait_words("t3_count", 2*N, 60);
        check_seq("t3_frame_1", 0, 300, N);
        check_seq("t3_frame_2", N, 400, N);
        repeat (10) cyc();
        chk("t3_no_frame3", 32'(got_q.size()), 32'(2*N));
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);
        chk("t3_tready_drained", 32'(s_axis_tready), 32'd1);

        // Reset after a partial frame, then a fresh frame.
        do_reset();
        got_q.delete();
        for (int i = 0; i < 5; i++) send(LW'(i), W'(600 + i));
        do_reset();
        for (int i = N-1; i >= 0; i--) send(LW'(i), W'(700 + i));
        wait_words("t4_count", N, 40);
        check_seq("t4_frame", 0, 700, N);
        repeat (10) cyc();
        chk("t4_no_extra", 32'(got_q.size()), 32'(N));
        chk("t4_hold_errs", 32'(hold_errs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
